// File: rtl/fifo_pkg.sv
// Shared FIFO package: default word width and ring depth used by both the
// put-side cell array and the get-side controller, plus the counter width.
package fifo_pkg;

    localparam int N_BITS_DEF  = 32;   // width of one data word
    localparam int N_CELLS_DEF = 4;    // cells in the FIFO ring (legal 2..16)
    localparam int COUNT_W     = 16;   // width of the dequeue counter

endpackage : fifo_pkg

// File: rtl/onehot_mux.sv
// One-hot word selector.
// Ports:
//   i_sel   - one-hot select, bit i picks word i
//   i_data  - concatenated input words, word i at [i*W +: W]
//   o_word  - selected word (all zeros when i_sel is zero)
module onehot_mux #(
    parameter int N_IN = 4,
    parameter int W    = 32
) (
    input  logic [N_IN-1:0]   i_sel,
    input  logic [N_IN*W-1:0] i_data,
    output logic [W-1:0]      o_word
);

    logic [W-1:0] w_word;

    // AND-OR structure: no priority chain, relies on the select being one-hot.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i_sel[i]) begin
                w_word = w_word | i_data[i*W +: W];
            end
        end
    end

    assign o_word = w_word;

endmodule : onehot_mux

// File: rtl/fifo_get_ctrl.sv
// Get-side controller of a ring FIFO. A one-hot token walks the cell ring;
// a request is accepted when the token cell is full, the cell is cleared in
// the same cycle and its word appears registered on data_get one cycle later.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req_get      - consumer dequeue request
//   cell_full    - per-cell full flags from the cell array
//   cell_data    - concatenated cell words, cell i at [i*N_BITS +: N_BITS]
//   en_get       - dequeue accepted this cycle (combinational)
//   cell_clear   - one-hot clear strobe to the cell being read (combinational)
//   empty        - token cell holds no data (combinational)
//   data_get     - registered dequeued word
//   valid_get    - one-cycle pulse marking a fresh data_get
//   get_count    - running count of accepted dequeues (wraps)
module fifo_get_ctrl
    import fifo_pkg::*;
#(
    parameter int N_BITS  = N_BITS_DEF,
    parameter int N_CELLS = N_CELLS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_get,
    input  logic [N_CELLS-1:0]        cell_full,
    input  logic [N_CELLS*N_BITS-1:0] cell_data,
    output logic                      en_get,
    output logic [N_CELLS-1:0]        cell_clear,
    output logic                      empty,
    output logic [N_BITS-1:0]         data_get,
    output logic                      valid_get,
    output logic [COUNT_W-1:0]        get_count
);

    localparam logic [N_CELLS-1:0] TOKEN_INIT = N_CELLS'(1);

    logic [N_CELLS-1:0] r_token;
    logic [N_BITS-1:0]  r_data;
    logic               r_valid;
    logic [COUNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_en_get;
    logic [N_CELLS-1:0] w_token_next;
    logic [N_BITS-1:0]  w_word;

    // Flags are used straight from the cell array so a cell filling in the
    // same cycle as the request is honoured; only the token cell matters.
    assign w_empty      = ~|(cell_full & r_token);
    assign w_en_get     = req_get & ~w_empty & ~reset;
    assign w_token_next = {r_token[N_CELLS-2:0], r_token[N_CELLS-1]};

    onehot_mux #(
        .N_IN (N_CELLS),
        .W    (N_BITS)
    ) u_word_mux (
        .i_sel  (r_token),
        .i_data (cell_data),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_token <= TOKEN_INIT;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (w_en_get) begin
            r_token <= w_token_next;
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_count <= r_count + COUNT_W'(1);
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign empty      = w_empty;
    assign en_get     = w_en_get;
    assign cell_clear = w_en_get ? r_token : '0;
    assign data_get   = r_data;
    assign valid_get  = r_valid;
    assign get_count  = r_count;

endmodule : fifo_get_ctrl

// File: doc/fifo_get_ctrl.md
FIFO_GET_CTRL -- requirements
Module: fifo_get_ctrl

Interface
REQ-001 Parameter N_BITS, default 32, width of one data word.
REQ-002 Parameter N_CELLS, default 4, number of cells in the FIFO ring; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_get  input  1  consumer request to dequeue one word this cycle.
REQ-006 cell_full  input  N_CELLS  per-cell full flag from the cell array; bit i = cell i holds valid data.
REQ-007 cell_data  input  N_CELLS*N_BITS  concatenated cell outputs; cell i occupies bits [i*N_BITS +: N_BITS].
REQ-008 en_get  output  1  dequeue accepted this cycle (combinational).
REQ-009 cell_clear  output  N_CELLS  one-hot clear strobe to the cell being read (combinational).
REQ-010 empty  output  1  cell under the get token holds no data (combinational).
REQ-011 data_get  output  N_BITS  registered dequeued word.
REQ-012 valid_get  output  1  data_get updated by the previous edge; high for exactly one cycle per dequeue.
REQ-013 get_count  output  16  registered running count of accepted dequeues.

Function
REQ-014 A one-hot get token of N_CELLS bits SHALL mark the cell to read next.
REQ-015 empty SHALL equal ~|(cell_full & token).
REQ-016 en_get SHALL equal req_get & ~empty & ~reset.
REQ-017 cell_clear SHALL equal token when en_get=1, else all zeros.
REQ-018 On an edge with en_get=1: data_get <= word of the token cell; valid_get <= 1; token rotates one position up; get_count increments.
REQ-019 Token wrap: cell N_CELLS-1 SHALL be followed by cell 0.
REQ-020 On an edge with en_get=0: valid_get <= 0; data_get, token and get_count SHALL hold.
REQ-021 Latency: request accepted in cycle t, word visible on data_get with valid_get=1 in cycle t+1.
REQ-022 Back-to-back requests against full cells SHALL dequeue one word per cycle with no bubbles.
REQ-023 req_get while empty=1 SHALL be ignored with no state change and no cell_clear; the consumer must re-request.
REQ-024 A cell_full rising in the same cycle as a request SHALL be honoured in that cycle (flags sampled combinationally, no internal flag register).
REQ-025 Full flags of cells other than the token cell SHALL not affect any output.
REQ-026 get_count SHALL wrap 16'hFFFF -> 16'h0000 silently.

Reset
REQ-027 While reset=1 at an edge: token <= one-hot cell 0, data_get <= 0, valid_get <= 0, get_count <= 0.
REQ-028 Reset SHALL dominate req_get; en_get and cell_clear SHALL be 0 throughout any cycle with reset=1.
REQ-029 Reset mid-stream SHALL discard token position; the first post-reset dequeue reads cell 0.

Structure
REQ-030 N_BITS and N_CELLS defaults SHALL reside in shared package fifo_pkg, also used by the put-side cells.
REQ-031 Word selection SHALL be a sub-module onehot_mux (one-hot select, N_CELLS inputs of N_BITS) reused by the datapath.
REQ-032 Token, data_get, valid_get, get_count are the only registers; no latches.

Verification
REQ-033 Reset, then cell_full=4'b0000, req_get=1 for 3 cycles -> empty=1, en_get=0, cell_clear=0, valid_get=0, get_count=0.
REQ-034 cell_full=4'b1111, cell_data words 0xA0..0xA3, req_get=1 for 4 cycles -> cell_clear 0001,0010,0100,1000; data_get A0,A1,A2,A3 each one cycle later; get_count=4.
REQ-035 Continue with 5th request, cell_full=4'b0001 -> wrap reads cell 0, data_get=0xA0, get_count=5.
REQ-036 Token at cell 2, cell_full=4'b1011, req_get=1 -> empty=1, no dequeue; raise bit 2 same cycle as request -> dequeue occurs in that cycle.
REQ-037 Token at cell 3, reset=1 with req_get=1 and cell_full=1111 -> no cell_clear; after reset the first dequeue reads cell 0.
REQ-038 Preload get_count path with 65535 dequeues (or force) then one more -> get_count=0, valid_get=1.
